// File: rtl/obi_memory_responder_pkg.sv
// Shared types and helpers for the OBI memory responder.
//   resp_entry_t   : one queued response (read data, error flag)
//   byte_off_width : number of byte-offset address bits for a data width
//   word_idx_width : number of word-index address bits for a memory depth
package obi_memory_responder_pkg;

    // Widest supported data bus; narrower builds use the low bits of rdata.
    localparam int unsigned MaxDataWidth = 64;

    typedef struct packed {
        logic [MaxDataWidth-1:0] rdata;
        logic                    err;
    } resp_entry_t;

    function automatic int unsigned byte_off_width(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int unsigned word_idx_width(input int unsigned depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/obi_memory_responder_if.sv
// OBI memory bus bundle (address phase + response phase).
//   master : initiator side (drives req/addr/we/be/wdata/rready)
//   slave  : responder side (drives gnt/rvalid/rdata[/err])
// err exists only when OBI_MEMORY_RESPONDER_ERR_EN is defined.
interface obi_memory_responder_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    req;
    logic                    gnt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
`ifdef OBI_MEMORY_RESPONDER_ERR_EN
    logic                    err;

    modport master (
        output req, addr, we, be, wdata, rready,
        input  gnt, rvalid, rdata, err
    );
    modport slave (
        input  req, addr, we, be, wdata, rready,
        output gnt, rvalid, rdata, err
    );
`else
    modport master (
        output req, addr, we, be, wdata, rready,
        input  gnt, rvalid, rdata
    );
    modport slave (
        input  req, addr, we, be, wdata, rready,
        output gnt, rvalid, rdata
    );
`endif
endinterface

// File: rtl/obi_memory_resp_fifo.sv
// Synchronous response FIFO with async active-low reset.
//   clk, reset_n        : clock / reset
//   push, push_data     : enqueue (caller guarantees not full)
//   pop, pop_data       : dequeue (caller guarantees not empty); pop_data is the head
//   full, empty, count  : occupancy status
// Pointers wrap modulo Depth, so Depth need not be a power of two here.
module obi_memory_resp_fifo #(
    parameter int unsigned Depth    = 2,
    parameter type         entry_t  = logic,
    parameter int unsigned CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                push,
    input  entry_t              push_data,
    input  logic                pop,
    output entry_t              pop_data,
    output logic                full,
    output logic                empty,
    output logic [CntWidth-1:0] count
);
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    entry_t                store_q [Depth];
    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]   count_q, count_d;

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        if (p == PtrWidth'(Depth - 1)) return '0;
        return p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) store_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = store_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = (count_q == CntWidth'(Depth));
    assign empty    = (count_q == '0);

endmodule

// File: rtl/obi_memory_responder.sv
// OBI memory responder: grants address-phase requests when the response FIFO has room,
// performs byte-enabled reads/writes on a word-addressed memory and returns in-order
// responses through the FIFO.
//   clk, reset_n : clock, async active-low reset (flushes responses, keeps memory)
//   bus          : OBI slave modport (req/gnt, addr, we, be, wdata, rvalid/rready, rdata[, err])
// Optional feature macro: OBI_MEMORY_RESPONDER_ERR_EN -- out-of-range addresses return
// err=1 with rdata=0 and suppress writes; without it, addresses wrap modulo memory size.
module obi_memory_responder
    import obi_memory_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MEM_DEPTH_WORDS = 1024,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input logic                   clk,
    input logic                   reset_n,
    obi_memory_responder_if.slave bus
);
    localparam int unsigned OffWidth = byte_off_width(DATA_WIDTH);
    localparam int unsigned IdxWidth = word_idx_width(MEM_DEPTH_WORDS);
    localparam int unsigned NumBytes = DATA_WIDTH / 8;
    localparam int unsigned CntWidth = $clog2(MAX_OUTSTANDING + 1);

    logic                  ready_q;
    logic                  accept;
    logic                  pop;
    logic                  in_range;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CntWidth-1:0]   fifo_count;
    logic [IdxWidth-1:0]   word_idx;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH_WORDS];
    resp_entry_t           push_entry;
    resp_entry_t           head_entry;
    logic                  unused_bits;

    // Holds gnt low while in reset and until the first edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ready_q <= 1'b0;
        else          ready_q <= 1'b1;
    end

    assign word_idx = bus.addr[OffWidth +: IdxWidth];

`ifdef OBI_MEMORY_RESPONDER_ERR_EN
    assign in_range = ((bus.addr >> (OffWidth + IdxWidth)) == '0);
`else
    assign in_range = 1'b1;
`endif

    // Registered-only: a pop in the same cycle does not reopen a full FIFO.
    assign bus.gnt = ready_q && !fifo_full;
    assign accept  = bus.req && bus.gnt;
    assign pop     = bus.rvalid && bus.rready;

    // Read data comes from the pre-edge array contents, ahead of any write this cycle.
    always_comb begin
        push_entry     = '0;
        push_entry.err = !in_range;
        if (!bus.we && in_range) push_entry.rdata[DATA_WIDTH-1:0] = mem_q[word_idx];
    end

    always_ff @(posedge clk) begin
        if (accept && bus.we && in_range) begin
            for (int i = 0; i < NumBytes; i++) begin
                if (bus.be[i]) mem_q[word_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    obi_memory_resp_fifo #(
        .Depth   (MAX_OUTSTANDING),
        .entry_t (resp_entry_t)
    ) u_resp_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (accept),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.rvalid = !fifo_empty;
    assign bus.rdata  = fifo_empty ? '0 : head_entry.rdata[DATA_WIDTH-1:0];
`ifdef OBI_MEMORY_RESPONDER_ERR_EN
    assign bus.err    = !fifo_empty && head_entry.err;
`endif

    // Address offset/upper bits, unused rdata width and status are intentionally ignored.
    assign unused_bits = ^{head_entry, bus.addr, fifo_count};

endmodule

// File: tb/tb_obi_memory_responder.sv
// Self-checking bench for obi_memory_responder: directed scenarios followed by random
// traffic, checked cycle by cycle against a behavioural memory + response-queue model.
module tb_obi_memory_responder;
    import obi_memory_responder_pkg::*;

    localparam int unsigned MaxOut   = 2;
    localparam int unsigned Depth    = 1024;
`ifdef OBI_MEMORY_RESPONDER_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        bit          known;
        bit          err;
    } resp_m_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    obi_memory_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    obi_memory_responder #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MEM_DEPTH_WORDS (Depth),
        .MAX_OUTSTANDING (MaxOut)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    resp_m_t     q[$];
    logic [31:0] mem_m [Depth];
    bit [3:0]    known_m [Depth];
    bit          ready_m = 1'b0;
    int          gnt_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: called mid-cycle (after negedge), drives inputs, checks outputs
    // against the model, advances the model, and returns after the next negedge.
    task automatic cycle(input logic r, input logic [31:0] a, input logic w,
                         input logic [3:0] b, input logic [31:0] d, input logic rr);
        bit      exp_gnt, acc, pop, in_rng;
        int      idx;
        resp_m_t e;
        bus.req = r; bus.addr = a; bus.we = w; bus.be = b; bus.wdata = d; bus.rready = rr;
        #1;
        exp_gnt = ready_m && (q.size() < MaxOut);
        chk("gnt", bus.gnt, exp_gnt);
        chk("rvalid", bus.rvalid, q.size() != 0);
        gnt_seen += bus.gnt ? 1 : 0;
        if (q.size() != 0) begin
            if (q[0].known) chk("rdata", bus.rdata, q[0].rdata);
`ifdef OBI_MEMORY_RESPONDER_ERR_EN
            chk("err", bus.err, q[0].err);
`endif
        end
        acc = r && exp_gnt;
        pop = (q.size() != 0) && rr;
        if (pop) void'(q.pop_front());
        if (acc) begin
            in_rng = !ErrEn || (a < Depth * 4);
            idx    = int'((a / 4) % Depth);
            e.err  = !in_rng;
            if (w || !in_rng) begin
                e.rdata = 32'h0;
                e.known = 1'b1;
            end else begin
                e.rdata = mem_m[idx];
                e.known = (known_m[idx] == 4'hF);
            end
            if (w && in_rng) begin
                for (int i = 0; i < 4; i++) begin
                    if (b[i]) begin
                        mem_m[idx][8*i +: 8] = d[8*i +: 8];
                        known_m[idx][i]      = 1'b1;
                    end
                end
            end
            q.push_back(e);
        end
        @(posedge clk);
        if (reset_n) ready_m = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
    endtask

    initial begin
        logic [31:0] ra;
        reset_n = 1'b0;
        bus.req = 1'b0; bus.addr = '0; bus.we = 1'b0; bus.be = '0; bus.wdata = '0;
        bus.rready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", bus.gnt, 1'b0);
        chk("rst_rvalid", bus.rvalid, 1'b0);
        chk("rst_rdata", bus.rdata, 32'h0);
`ifdef OBI_MEMORY_RESPONDER_ERR_EN
        chk("rst_err", bus.err, 1'b0);
`endif
        reset_n = 1'b1;
        idle(1);

        // Full write then read-back.
        cycle(1'b1, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 1'b1);
        cycle(1'b1, 32'h10, 1'b0, 4'h0, 32'h0, 1'b1);
        idle(2);

        // Partial write with byte enables.
        cycle(1'b1, 32'h20, 1'b1, 4'hF, 32'h11223344, 1'b1);
        cycle(1'b1, 32'h20, 1'b1, 4'b0101, 32'hAABBCCDD, 1'b1);
        cycle(1'b1, 32'h20, 1'b0, 4'h0, 32'h0, 1'b1);
        idle(1);
        chk("be_merge", mem_m[8], 32'h11BB33DD);
        idle(1);

        // Backpressure: two accepted, third held off until the first pop.
        cycle(1'b1, 32'h10, 1'b0, 4'h0, 32'h0, 1'b0);
        cycle(1'b1, 32'h20, 1'b0, 4'h0, 32'h0, 1'b0);
        cycle(1'b1, 32'h10, 1'b0, 4'h0, 32'h0, 1'b0);
        cycle(1'b1, 32'h10, 1'b0, 4'h0, 32'h0, 1'b0);
        cycle(1'b1, 32'h10, 1'b0, 4'h0, 32'h0, 1'b1);
        cycle(1'b1, 32'h10, 1'b0, 4'h0, 32'h0, 1'b1);
        idle(3);

        // Back-to-back: one accept per cycle with rready high.
        gnt_seen = 0;
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'(i * 4) & 32'h3C, 1'b0, 4'h0, 32'h0, 1'b1);
        chk("b2b_accepts", 32'(gnt_seen), 32'd8);
        idle(2);

        // Reset with two pending responses; memory must survive.
        cycle(1'b1, 32'h10, 1'b0, 4'h0, 32'h0, 1'b0);
        cycle(1'b1, 32'h20, 1'b0, 4'h0, 32'h0, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("midrst_rvalid", bus.rvalid, 1'b0);
        chk("midrst_gnt", bus.gnt, 1'b0);
        q.delete();
        ready_m = 1'b0;
        #1;
        reset_n = 1'b1;
        idle(1);
        cycle(1'b1, 32'h10, 1'b0, 4'h0, 32'h0, 1'b1);
        idle(2);

        // Out-of-range: error response or wrap depending on build.
        cycle(1'b1, 32'h0, 1'b1, 4'hF, 32'h0BADF00D, 1'b1);
        cycle(1'b1, 32'h1000, 1'b0, 4'h0, 32'h0, 1'b1);
        cycle(1'b1, 32'h1000, 1'b1, 4'hF, 32'h5A5A1234, 1'b1);
        cycle(1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
        idle(2);

        // Random traffic over a small initialised window plus out-of-range aliases.
        for (int i = 0; i < 16; i++) cycle(1'b1, 32'(i * 4), 1'b1, 4'hF, $urandom, 1'b1);
        for (int i = 0; i < 400; i++) begin
            ra = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) ra = ra | 32'h1000;
            cycle($urandom_range(0, 3) != 0, ra, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3) != 0);
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
